// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch (T0-T2) then a class-specific execute
// sequence (T3-T7), producing every datapath strobe from the current step.
module control_sequencer #(
  parameter int OPW  = 5,
  parameter int ALUW = 3
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [OPW-1:0]  opcode,
  input  logic            con_ff,
  input  logic            stop,
  output logic            PCout,
  output logic            ZLowout,
  output logic            ZHighout,
  output logic            MDRout,
  output logic            HIout,
  output logic            LOout,
  output logic            Cout,
  output logic            Rout,
  output logic            BAout,
  output logic            PCin,
  output logic            IRin,
  output logic            MARin,
  output logic            MDRin,
  output logic            Yin,
  output logic            ZLowIn,
  output logic            ZHighIn,
  output logic            HIin,
  output logic            LOin,
  output logic            Rin,
  output logic            CONin,
  output logic            GRA,
  output logic            GRB,
  output logic            GRC,
  output logic            IncPC,
  output logic            Read,
  output logic            RAMin,
  output logic [ALUW-1:0] alu_op,
  output logic            run
);

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_t;

  localparam logic [OPW-1:0] OP_LD   = OPW'(5'd0);
  localparam logic [OPW-1:0] OP_LDI  = OPW'(5'd1);
  localparam logic [OPW-1:0] OP_ST   = OPW'(5'd2);
  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'd3);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'd4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'd5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'd6);
  localparam logic [OPW-1:0] OP_SHR  = OPW'(5'd7);
  localparam logic [OPW-1:0] OP_SHL  = OPW'(5'd8);
  localparam logic [OPW-1:0] OP_ADDI = OPW'(5'd9);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(5'd10);
  localparam logic [OPW-1:0] OP_DIV  = OPW'(5'd11);
  localparam logic [OPW-1:0] OP_BR   = OPW'(5'd12);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'd13);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'd15);

  localparam logic [ALUW-1:0] ALU_ADD = ALUW'(3'd0);
  localparam logic [ALUW-1:0] ALU_MUL = ALUW'(3'd6);
  localparam logic [ALUW-1:0] ALU_DIV = ALUW'(3'd7);

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  step_s;
  logic [2:0]  exec_len_s;
  logic        boundary_s;

  // Number of execute steps (T3 onward) for an opcode class.
  function automatic logic [2:0] exec_len(input logic [OPW-1:0] op);
    case (op)
      OP_LD, OP_ST:                            exec_len = 3'd5;
      OP_LDI, OP_ADDI, OP_ADD, OP_SUB,
      OP_AND, OP_OR, OP_SHR, OP_SHL:           exec_len = 3'd3;
      OP_MUL, OP_DIV, OP_BR:                   exec_len = 3'd4;
      default:                                 exec_len = 3'd1;
    endcase
  endfunction

  // State register; clr forces RST immediately.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_r <= S_RST;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Execute step index and instruction-boundary detection.
  always_comb begin
    step_s = 3'd0;
    case (state_r)
      S_T3:    step_s = 3'd0;
      S_T4:    step_s = 3'd1;
      S_T5:    step_s = 3'd2;
      S_T6:    step_s = 3'd3;
      S_T7:    step_s = 3'd4;
      default: step_s = 3'd0;
    endcase
    exec_len_s = exec_len(opcode);
    // ">=" sends a step past the class length to the boundary rather than onward
    boundary_s = ({1'b0, step_s} + 4'd1) >= {1'b0, exec_len_s};
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_RST:  state_nxt_s = S_T0;
      S_T0:   state_nxt_s = S_T1;
      S_T1:   state_nxt_s = S_T2;
      S_T2:   state_nxt_s = S_T3;
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        if ((state_r == S_T3) && (opcode == OP_HALT)) begin
          state_nxt_s = S_HALT;
        end else if (boundary_s) begin
          state_nxt_s = stop ? S_HALT : S_T0;
        end else begin
          state_nxt_s = state_t'(state_r + 4'd1);
        end
      end
      S_HALT: state_nxt_s = S_HALT;
      default: state_nxt_s = S_RST;
    endcase
  end

  // Strobe decode from the current step and opcode class.
  always_comb begin
    PCout = 1'b0; ZLowout = 1'b0; ZHighout = 1'b0; MDRout = 1'b0;
    HIout = 1'b0; LOout = 1'b0; Cout = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCin = 1'b0; IRin = 1'b0; MARin = 1'b0; MDRin = 1'b0; Yin = 1'b0;
    ZLowIn = 1'b0; ZHighIn = 1'b0; HIin = 1'b0; LOin = 1'b0; Rin = 1'b0;
    CONin = 1'b0; GRA = 1'b0; GRB = 1'b0; GRC = 1'b0;
    IncPC = 1'b0; Read = 1'b0; RAMin = 1'b0;
    alu_op = ALU_ADD;
    run = 1'b0;
    case (state_r)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1;
      end
      S_T1: begin
        run = 1'b1; ZLowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3, S_T4, S_T5, S_T6, S_T7: begin
        run = 1'b1;
        case (opcode)
          OP_LD, OP_ST: begin
            case (state_r)
              S_T3: begin GRB = 1'b1; BAout = 1'b1; Yin = 1'b1; end
              S_T4: begin Cout = 1'b1; ZLowIn = 1'b1; end
              S_T5: begin ZLowout = 1'b1; MARin = 1'b1; end
              S_T6: begin
                MDRin = 1'b1;
                if (opcode == OP_LD) begin
                  Read = 1'b1;
                end else begin
                  GRA = 1'b1; Rout = 1'b1;
                end
              end
              S_T7: begin
                if (opcode == OP_LD) begin
                  MDRout = 1'b1; GRA = 1'b1; Rin = 1'b1;
                end else begin
                  RAMin = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_LDI, OP_ADDI: begin
            case (state_r)
              S_T3: begin
                GRB = 1'b1; Yin = 1'b1;
                // ldi takes base-or-zero through BA; addi always reads the register
                if (opcode == OP_LDI) begin
                  BAout = 1'b1;
                end else begin
                  Rout = 1'b1;
                end
              end
              S_T4: begin Cout = 1'b1; ZLowIn = 1'b1; end
              S_T5: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL: begin
            case (state_r)
              S_T3: begin GRB = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T4: begin
                GRC = 1'b1; Rout = 1'b1; ZLowIn = 1'b1;
                alu_op = ALUW'(opcode - OP_ADD);
              end
              S_T5: begin ZLowout = 1'b1; GRA = 1'b1; Rin = 1'b1; end
              default: ;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (state_r)
              S_T3: begin GRA = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              S_T4: begin
                GRB = 1'b1; Rout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1;
                alu_op = (opcode == OP_DIV) ? ALU_DIV : ALU_MUL;
              end
              S_T5: begin ZLowout = 1'b1; LOin = 1'b1; end
              S_T6: begin ZHighout = 1'b1; HIin = 1'b1; end
              default: ;
            endcase
          end
          OP_BR: begin
            case (state_r)
              S_T3: begin GRA = 1'b1; Rout = 1'b1; CONin = 1'b1; end
              S_T4: begin PCout = 1'b1; Yin = 1'b1; end
              S_T5: begin Cout = 1'b1; ZLowIn = 1'b1; end
              S_T6: begin ZLowout = 1'b1; PCin = con_ff; end
              default: ;
            endcase
          end
          OP_JR: begin
            if (state_r == S_T3) begin
              GRA = 1'b1; Rout = 1'b1; PCin = 1'b1;
            end else begin
              PCin = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: each instruction's strobe trace is
// built from a per-class step table and compared cycle by cycle.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       clr = 1'b0;
  logic [4:0] opcode = 5'd0;
  logic       con_ff = 1'b0;
  logic       stop = 1'b0;
  logic PCout, ZLowout, ZHighout, MDRout, HIout, LOout, Cout, Rout, BAout;
  logic PCin, IRin, MARin, MDRin, Yin, ZLowIn, ZHighIn, HIin, LOin, Rin, CONin;
  logic GRA, GRB, GRC, IncPC, Read, RAMin, run;
  logic [2:0] alu_op;

  always #5 clk = ~clk;

  control_sequencer #(.OPW(5), .ALUW(3)) dut (
    .clk(clk), .clr(clr), .opcode(opcode), .con_ff(con_ff), .stop(stop),
    .PCout(PCout), .ZLowout(ZLowout), .ZHighout(ZHighout), .MDRout(MDRout),
    .HIout(HIout), .LOout(LOout), .Cout(Cout), .Rout(Rout), .BAout(BAout),
    .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
    .ZLowIn(ZLowIn), .ZHighIn(ZHighIn), .HIin(HIin), .LOin(LOin), .Rin(Rin),
    .CONin(CONin), .GRA(GRA), .GRB(GRB), .GRC(GRC), .IncPC(IncPC),
    .Read(Read), .RAMin(RAMin), .alu_op(alu_op), .run(run)
  );

  localparam logic [29:0] PCOUT   = 30'd1 << 0;
  localparam logic [29:0] ZLOWOUT = 30'd1 << 1;
  localparam logic [29:0] ZHIOUT  = 30'd1 << 2;
  localparam logic [29:0] MDROUT  = 30'd1 << 3;
  localparam logic [29:0] COUT    = 30'd1 << 6;
  localparam logic [29:0] ROUT    = 30'd1 << 7;
  localparam logic [29:0] BAOUT   = 30'd1 << 8;
  localparam logic [29:0] PCIN    = 30'd1 << 9;
  localparam logic [29:0] IRIN    = 30'd1 << 10;
  localparam logic [29:0] MARIN   = 30'd1 << 11;
  localparam logic [29:0] MDRIN   = 30'd1 << 12;
  localparam logic [29:0] YIN     = 30'd1 << 13;
  localparam logic [29:0] ZLOWIN  = 30'd1 << 14;
  localparam logic [29:0] ZHIIN   = 30'd1 << 15;
  localparam logic [29:0] HIIN    = 30'd1 << 16;
  localparam logic [29:0] LOIN    = 30'd1 << 17;
  localparam logic [29:0] RIN     = 30'd1 << 18;
  localparam logic [29:0] CONIN   = 30'd1 << 19;
  localparam logic [29:0] GRA_M   = 30'd1 << 20;
  localparam logic [29:0] GRB_M   = 30'd1 << 21;
  localparam logic [29:0] GRC_M   = 30'd1 << 22;
  localparam logic [29:0] INCPC   = 30'd1 << 23;
  localparam logic [29:0] READ    = 30'd1 << 24;
  localparam logic [29:0] RAMIN   = 30'd1 << 25;
  localparam logic [29:0] RUN     = 30'd1 << 29;

  logic [29:0] obs;
  assign obs = {run, alu_op, RAMin, Read, IncPC, GRC, GRB, GRA, CONin, Rin,
                LOin, HIin, ZHighIn, ZLowIn, Yin, MDRin, MARin, IRin, PCin,
                BAout, Rout, Cout, LOout, HIout, MDRout, ZHighout, ZLowout, PCout};

  int n_tests = 0;
  int n_fail  = 0;
  logic [29:0] seq[$];

  task automatic chk(input string tag, input logic [29:0] got, input logic [29:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] alu(input int v);
    return 30'(v) << 26;
  endfunction

  // Expected per-cycle strobe trace of one instruction, fetch included.
  task automatic build(input logic [4:0] op, input logic cf, output bit to_halt);
    seq.delete();
    to_halt = 1'b0;
    seq.push_back(RUN | PCOUT | MARIN | INCPC | ZLOWIN);
    seq.push_back(RUN | ZLOWOUT | PCIN | READ | MDRIN);
    seq.push_back(RUN | MDROUT | IRIN);
    if (op == 5'd0 || op == 5'd2) begin
      seq.push_back(RUN | GRB_M | BAOUT | YIN);
      seq.push_back(RUN | COUT | ZLOWIN);
      seq.push_back(RUN | ZLOWOUT | MARIN);
      if (op == 5'd0) begin
        seq.push_back(RUN | READ | MDRIN);
        seq.push_back(RUN | MDROUT | GRA_M | RIN);
      end else begin
        seq.push_back(RUN | GRA_M | ROUT | MDRIN);
        seq.push_back(RUN | RAMIN);
      end
    end else if (op == 5'd1 || op == 5'd9) begin
      seq.push_back(RUN | GRB_M | ((op == 5'd1) ? BAOUT : ROUT) | YIN);
      seq.push_back(RUN | COUT | ZLOWIN);
      seq.push_back(RUN | ZLOWOUT | GRA_M | RIN);
    end else if (op >= 5'd3 && op <= 5'd8) begin
      seq.push_back(RUN | GRB_M | ROUT | YIN);
      seq.push_back(RUN | GRC_M | ROUT | ZLOWIN | alu(int'(op) - 3));
      seq.push_back(RUN | ZLOWOUT | GRA_M | RIN);
    end else if (op == 5'd10 || op == 5'd11) begin
      seq.push_back(RUN | GRA_M | ROUT | YIN);
      seq.push_back(RUN | GRB_M | ROUT | ZHIIN | ZLOWIN | alu((op == 5'd11) ? 7 : 6));
      seq.push_back(RUN | ZLOWOUT | LOIN);
      seq.push_back(RUN | ZHIOUT | HIIN);
    end else if (op == 5'd12) begin
      seq.push_back(RUN | GRA_M | ROUT | CONIN);
      seq.push_back(RUN | PCOUT | YIN);
      seq.push_back(RUN | COUT | ZLOWIN);
      seq.push_back(RUN | ZLOWOUT | (cf ? PCIN : 30'd0));
    end else if (op == 5'd13) begin
      seq.push_back(RUN | GRA_M | ROUT | PCIN);
    end else begin
      seq.push_back(RUN);
      to_halt = (op == 5'd15);
    end
  endtask

  // Runs one instruction; stop is held high from step stop_from until the
  // last step, where it takes stop_end. abort_at >= 0 returns mid-instruction.
  task automatic run_instr(input logic [4:0] op, input logic cf, input int stop_from,
                           input bit stop_end, input int abort_at, input string nm);
    bit to_halt;
    int last;
    build(op, cf, to_halt);
    last = seq.size() - 1;
    for (int i = 0; i <= last; i++) begin
      @(negedge clk);
      chk($sformatf("%s_op%0d_T%0d", nm, op, i), obs, seq[i]);
      chk($sformatf("%s_bus_onehot", nm), 30'($countones(obs[8:0]) <= 1), 30'd1);
      if (i == 0) begin
        opcode = op;
        con_ff = cf;
      end
      if (i == abort_at) return;
      stop = (i == last) ? stop_end : (stop_from >= 0 && i >= stop_from);
    end
    if (to_halt || stop_end) begin
      repeat (10) begin
        @(negedge clk);
        chk({nm, "_halt"}, obs, 30'd0);
      end
    end
  endtask

  task automatic do_reset(input string nm);
    clr = 1'b0;
    #1;
    chk({nm, "_async"}, obs, 30'd0);
    repeat (3) begin
      @(negedge clk);
      chk({nm, "_rst"}, obs, 30'd0);
    end
    stop = 1'b0;
    opcode = 5'd0;
    con_ff = 1'b0;
    clr = 1'b1;
  endtask

  initial begin
    logic [4:0] op;
    logic       cf;
    int         sf;
    #2;
    do_reset("init");
    run_instr(5'd9,  1'b0, -1, 1'b0, -1, "addi");
    run_instr(5'd0,  1'b0, -1, 1'b0, -1, "ld");
    run_instr(5'd2,  1'b0, -1, 1'b0, -1, "st");
    run_instr(5'd4,  1'b0, -1, 1'b0, -1, "sub");
    run_instr(5'd11, 1'b0, -1, 1'b0, -1, "div");
    run_instr(5'd12, 1'b1, -1, 1'b0, -1, "br_taken");
    run_instr(5'd12, 1'b0, -1, 1'b0, -1, "br_not");
    repeat (40) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd15) op = 5'd14;
      cf = 1'($urandom_range(0, 1));
      sf = $urandom_range(3, 8);
      run_instr(op, cf, sf, 1'b0, -1, "rnd");
    end
    run_instr(5'd3, 1'b0, 4, 1'b1, -1, "add_stop");
    do_reset("rst_after_stop");
    run_instr(5'd15, 1'b0, -1, 1'b0, -1, "halt");
    do_reset("rst_after_halt");
    run_instr(5'd0, 1'b0, -1, 1'b0, 6, "ld_abort");
    do_reset("rst_mid_ld");
    run_instr(5'd5, 1'b0, -1, 1'b0, -1, "and_restart");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
